// File: rtl/fp_pkg.sv
// Shared single-precision constants, field widths, state enum and word layout
// for the FPAU squaring unit.
package fp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned EXPC_W = 10;

  localparam int unsigned FP_BIAS = 127;

  localparam logic [WORD_W-1:0] FP_QNAN = 32'h7FC00000;
  localparam logic [WORD_W-1:0] FP_PINF = 32'h7F800000;
  localparam logic [WORD_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM,
    DONE
  } fp_sq_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_sq_mant_mul.sv
// Iterative 24x24 shift-add mantissa multiplier: one multiplier bit per cycle.
// start loads the operand (squared against itself); done_c flags the final iteration.
module fp_sq_mant_mul
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mant,
  output logic              done_c,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand;
  logic [MANT_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  assign done_c = busy && (cnt == CNT_W'(MANT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      product <= '0;
      mcand   <= PROD_W'(mant);
      mplier  <= mant;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done_c) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fp_square.sv
// IEEE-754 single-precision squaring unit S = A*A with valid/ready handshakes.
// Define FP_SQUARE_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_square
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] A,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] S
);

  localparam logic signed [EXPC_W-1:0] EXP_INF  = 10'sd255;
  localparam logic signed [EXPC_W-1:0] EXP_NONE = 10'sd0;

  fp_sq_state_e             state, state_d;
  fp32_t                    a_in;
  logic [EXP_W-1:0]         a_exp, a_exp_d;
  logic [WORD_W-1:0]        s_d, special_s, norm_s;
  logic                     is_special, start, mul_done;
  logic [PROD_W-1:0]        product;
  logic                     p_hi;
  logic [FRAC_W-1:0]        frac;
  logic signed [EXPC_W-1:0] e_c;
  logic                     unused_sign;

  assign a_in        = fp32_t'(A);
  assign unused_sign = a_in.sign;

  fp_sq_mant_mul u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mant   ({1'b1, a_in.frac}),
    .done_c (mul_done),
    .product(product)
  );

  // Zero/denormal flush, infinity and NaN bypass the multiplier.
  always_comb begin
    is_special = 1'b1;
    special_s  = FP_ZERO;
    if (a_in.exp == '0)      special_s = FP_ZERO;
    else if (a_in.exp == '1) special_s = (a_in.frac == '0) ? FP_PINF : FP_QNAN;
    else                     is_special = 1'b0;
  end

`ifdef FP_SQUARE_RNE_EN
  logic              guard, sticky, round_up;
  logic [FRAC_W:0]   frac_inc;
`else
  logic              unused_tail;
  assign unused_tail = ^product[PROD_W-FRAC_W-3:0];
`endif

  // Normalize the [1,4) product and pack with range clamping.
  always_comb begin
    p_hi = product[PROD_W-1];
    frac = p_hi ? product[PROD_W-2 -: FRAC_W] : product[PROD_W-3 -: FRAC_W];
    e_c  = EXPC_W'({1'b0, a_exp, 1'b0}) - EXPC_W'(FP_BIAS) + EXPC_W'(p_hi);
`ifdef FP_SQUARE_RNE_EN
    guard    = p_hi ? product[PROD_W-FRAC_W-2] : product[PROD_W-FRAC_W-3];
    sticky   = p_hi ? (|product[PROD_W-FRAC_W-3:0]) : (|product[PROD_W-FRAC_W-4:0]);
    round_up = guard & (sticky | frac[0]);
    frac_inc = {1'b0, frac} + (FRAC_W + 1)'(round_up);
    frac     = frac_inc[FRAC_W-1:0];
    e_c      = e_c + EXPC_W'(frac_inc[FRAC_W]);
`endif
    if (e_c >= EXP_INF)       norm_s = FP_PINF;
    else if (e_c <= EXP_NONE) norm_s = FP_ZERO;
    else                      norm_s = {1'b0, e_c[EXP_W-1:0], frac};
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d = state;
    s_d     = S;
    a_exp_d = a_exp;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_special) begin
            s_d     = special_s;
            state_d = DONE;
          end else begin
            a_exp_d = a_in.exp;
            start   = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: if (mul_done) state_d = NORM;
      NORM: begin
        s_d     = norm_s;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      S         <= FP_ZERO;
      a_exp     <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      S         <= s_d;
      a_exp     <= a_exp_d;
    end
  end

endmodule
